// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I instruction and its register operands into
// the ALU's SrcA/SrcB/Operation. The results sit in a one-entry pipeline
// register that supports a valid/ready handshake, stall and flush.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    // ALU operation encodings, in the form the ALU expects to receive them.
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_AND  = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR   = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLL  = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SRL  = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SRA  = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLTI = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLT  = 4'b1001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADDI = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BEQ  = 4'b1011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BNE  = 4'b1100;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BLT  = 4'b1101;
    localparam logic [OPCODE_LENGTH-1:0] ALU_BGE  = 4'b1110;
    localparam logic [OPCODE_LENGTH-1:0] ALU_LUI  = 4'b1111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] shamt_r;
    logic [DATA_WIDTH-1:0] shamt_i;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign f7b5    = instr[30];
    assign imm_i   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    // LUI hands the ALU the raw 20-bit field; the ALU applies the <<12 itself.
    assign imm_u   = {{(DATA_WIDTH-20){1'b0}}, instr[31:12]};
    assign shamt_r = {{(DATA_WIDTH-5){1'b0}}, rs2_data[4:0]};
    assign shamt_i = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]    dec_a;
    logic [DATA_WIDTH-1:0]    dec_b;
    logic                     dec_ill;

    // Decode the presented instruction into ALU operands and operation code.
    always_comb begin
        dec_op  = ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case (funct3)
                    3'b000: dec_op = f7b5 ? ALU_SUB : ALU_ADD;
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b100: dec_op = ALU_XOR;
                    3'b010: dec_op = ALU_SLT;
                    3'b001: begin
                        dec_op = ALU_SLL;
                        dec_b  = shamt_r;
                    end
                    3'b101: begin
                        dec_op = f7b5 ? ALU_SRA : ALU_SRL;
                        dec_b  = shamt_r;
                    end
                    default: dec_ill = 1'b1;  // sltu has no ALU code
                endcase
            end
            OPC_I: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_op = ALU_ADDI;
                    3'b010: dec_op = ALU_SLTI;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_op = ALU_SLL;
                        dec_b  = shamt_i;
                    end
                    3'b101: begin
                        dec_op = f7b5 ? ALU_SRA : ALU_SRL;
                        dec_b  = shamt_i;
                    end
                    default: dec_ill = 1'b1;  // sltiu has no ALU code
                endcase
            end
            OPC_LOAD: begin
                dec_op = ALU_ADD;
                dec_a  = rs1_data;
                dec_b  = imm_i;
            end
            OPC_STORE: begin
                dec_op = ALU_ADD;
                dec_a  = rs1_data;
                dec_b  = imm_s;
            end
            OPC_BRANCH: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case (funct3)
                    3'b000:  dec_op = ALU_BEQ;
                    3'b001:  dec_op = ALU_BNE;
                    3'b100:  dec_op = ALU_BLT;
                    3'b101:  dec_op = ALU_BGE;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_op = ALU_LUI;
                dec_a  = '0;
                dec_b  = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal instructions still issue, but with neutral operands.
        if (dec_ill) begin
            dec_op = ALU_ADD;
            dec_a  = '0;
            dec_b  = '0;
        end
    end

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high. Upstream may load whenever the register is empty or being drained
    // this cycle (in_ready = !out_valid || out_ready); flush overrides both a
    // load and a consume and leaves the register empty.
    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // One-entry pipeline register holding the decoded instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            SrcA      <= '0;
            SrcB      <= '0;
            Operation <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            SrcA      <= dec_a;
            SrcB      <= dec_b;
            Operation <= dec_op;
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage with hand-computed
// expected values for decode, handshake, stall, flush and reset behaviour.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  operation;
    logic        illegal;

    int checks;
    int failures;

    alu_issue_stage #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .instr(instr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .SrcA(src_a),
        .SrcB(src_b),
        .Operation(operation),
        .illegal(illegal)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one instruction; inputs change #1 after a rising edge.
    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = a;
        rs2_data = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || src_a !== 32'h0 || src_b !== 32'h0 || operation !== 4'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%h ill=%b, want all zero",
                     out_valid, src_a, src_b, operation, illegal);
        end
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] v_instr [12];
        logic [31:0] v_rs1   [12];
        logic [31:0] v_rs2   [12];
        logic [3:0]  e_op    [12];
        logic [31:0] e_a     [12];
        logic [31:0] e_b     [12];
        logic        e_ill   [12];
        // sub x0,x1,x2
        v_instr[0]  = 32'h40208033; v_rs1[0]  = 32'd10;       v_rs2[0]  = 32'd3;
        e_op[0] = 4'b0001; e_a[0]  = 32'd10;       e_b[0]  = 32'd3;          e_ill[0]  = 1'b0;
        // srai x1,x2,4
        v_instr[1]  = 32'h40415093; v_rs1[1]  = 32'h80000000; v_rs2[1]  = 32'h55;
        e_op[1] = 4'b0111; e_a[1]  = 32'h80000000; e_b[1]  = 32'd4;          e_ill[1]  = 1'b0;
        // addi x1,x2,-1
        v_instr[2]  = 32'hFFF10093; v_rs1[2]  = 32'd7;        v_rs2[2]  = 32'd9;
        e_op[2] = 4'b1010; e_a[2]  = 32'd7;        e_b[2]  = 32'hFFFFFFFF;   e_ill[2]  = 1'b0;
        // lui x1,0x12345
        v_instr[3]  = 32'h123450B7; v_rs1[3]  = 32'h1111;     v_rs2[3]  = 32'h2222;
        e_op[3] = 4'b1111; e_a[3]  = 32'h0;        e_b[3]  = 32'h00012345;   e_ill[3]  = 1'b0;
        // sltu: illegal
        v_instr[4]  = 32'h0020B033; v_rs1[4]  = 32'd5;        v_rs2[4]  = 32'd6;
        e_op[4] = 4'b0000; e_a[4]  = 32'h0;        e_b[4]  = 32'h0;          e_ill[4]  = 1'b1;
        // branch funct3=010: illegal
        v_instr[5]  = 32'h00002063; v_rs1[5]  = 32'd5;        v_rs2[5]  = 32'd6;
        e_op[5] = 4'b0000; e_a[5]  = 32'h0;        e_b[5]  = 32'h0;          e_ill[5]  = 1'b1;
        // or x0,x1,x2
        v_instr[6]  = 32'h0020E033; v_rs1[6]  = 32'hF0F0;     v_rs2[6]  = 32'h0F0F;
        e_op[6] = 4'b0011; e_a[6]  = 32'hF0F0;     e_b[6]  = 32'h0F0F;       e_ill[6]  = 1'b0;
        // sll x0,x1,x2: only rs2[4:0] is passed
        v_instr[7]  = 32'h00209033; v_rs1[7]  = 32'd1;        v_rs2[7]  = 32'hFFFFFF23;
        e_op[7] = 4'b0101; e_a[7]  = 32'd1;        e_b[7]  = 32'd3;          e_ill[7]  = 1'b0;
        // beq x1,x2
        v_instr[8]  = 32'h00208063; v_rs1[8]  = 32'd42;       v_rs2[8]  = 32'd43;
        e_op[8] = 4'b1011; e_a[8]  = 32'd42;       e_b[8]  = 32'd43;         e_ill[8]  = 1'b0;
        // bge x1,x2
        v_instr[9]  = 32'h0020D063; v_rs1[9]  = 32'd8;        v_rs2[9]  = 32'd9;
        e_op[9] = 4'b1110; e_a[9]  = 32'd8;        e_b[9]  = 32'd9;          e_ill[9]  = 1'b0;
        // lw x1,8(x2)
        v_instr[10] = 32'h00812083; v_rs1[10] = 32'h1000;     v_rs2[10] = 32'h77;
        e_op[10] = 4'b0000; e_a[10] = 32'h1000;    e_b[10] = 32'd8;          e_ill[10] = 1'b0;
        // sw x2,-4(x1)
        v_instr[11] = 32'hFE20AE23; v_rs1[11] = 32'h2000;     v_rs2[11] = 32'h99;
        e_op[11] = 4'b0000; e_a[11] = 32'h2000;    e_b[11] = 32'hFFFFFFFC;   e_ill[11] = 1'b0;

        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(v_instr[k], v_rs1[k], v_rs2[k]);
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || operation !== e_op[k] || src_a !== e_a[k] ||
                src_b !== e_b[k] || illegal !== e_ill[k]) begin
                failures++;
                $display("FAIL decode_%0d: got v=%b op=%b a=%h b=%h ill=%b, want v=1 op=%b a=%h b=%h ill=%b",
                         k, out_valid, operation, src_a, src_b, illegal, e_op[k], e_a[k], e_b[k], e_ill[k]);
            end
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL consume_clear_%0d: got out_valid=%b want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(32'h40208033, 32'd10, 32'd3);  // sub
        step();
        // Upstream now offers an or with different operands while stalled.
        drive(32'h0020E033, 32'hAAAA, 32'h5555);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || operation !== 4'b0001 ||
                src_a !== 32'd10 || src_b !== 32'd3) begin
                failures++;
                $display("FAIL stall_hold_%0d: got rdy=%b v=%b op=%b a=%h b=%h, want rdy=0 v=1 op=0001 a=0000000a b=00000003",
                         k, in_ready, out_valid, operation, src_a, src_b);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || operation !== 4'b0011 || src_a !== 32'hAAAA || src_b !== 32'h5555) begin
            failures++;
            $display("FAIL stall_replace: got v=%b op=%b a=%h b=%h, want v=1 op=0011 a=0000aaaa b=00005555",
                     out_valid, operation, src_a, src_b);
        end
        // Operands changing after the load edge must not disturb the held value.
        rs1_data = 32'hDEAD;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v_instr [3];
        logic [3:0]  e_op    [3];
        v_instr[0] = 32'h40208033; e_op[0] = 4'b0001;
        v_instr[1] = 32'h00208063; e_op[1] = 4'b1011;
        v_instr[2] = 32'h123450B7; e_op[2] = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(v_instr[k], 32'd100 + k, 32'd200 + k);
            step();
            checks++;
            if (out_valid !== 1'b1 || operation !== e_op[k] || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d: got v=%b op=%b rdy=%b, want v=1 op=%b rdy=1",
                         k, out_valid, operation, in_ready, e_op[k]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h40208033, 32'd10, 32'd3);
        step();
        drive(32'h123450B7, 32'd1, 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got out_valid=%b want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(32'h0020E033, 32'h1234, 32'h5678);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_stall_load: got out_valid=%b want 1", out_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || src_a !== 32'h0 || src_b !== 32'h0 || operation !== 4'h0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL mid_stall_reset: got v=%b a=%h b=%h op=%h ill=%b, want all zero",
                     out_valid, src_a, src_b, operation, illegal);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_decode();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
